// File: rtl/rca_pkg.sv
// ============================================================================
//  Module  : rca_pkg
//  Purpose : Shared constants and types for the ripple-carry adder primitive.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rca_pkg;

    localparam int RCA_DEFAULT_WIDTH = 8;

    // Full result of a default-width add: carry-out above the sum bits.
    typedef logic [RCA_DEFAULT_WIDTH:0] rca_result_t;

endpackage : rca_pkg

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
//  Module  : full_adder
//  Purpose : 1-bit combinational full adder, one stage of the ripple chain.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_prop;

    assign w_prop = a ^ b;
    assign s      = w_prop ^ ci;
    assign co     = (a & b) | (ci & w_prop);

endmodule : full_adder

`default_nettype wire

// File: rtl/ripple_carry_adder.sv
// ============================================================================
//  Module  : ripple_carry_adder
//  Purpose : Registered WIDTH-bit ripple-carry adder with carry-in/out.
//            Define RCA_OVERFLOW_EN to add the registered signed-overflow Ovf.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_carry_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
`ifdef RCA_OVERFLOW_EN
    output logic             Ovf,
`endif
    output logic             out_valid
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;
    logic             valid_d, valid_q;

    assign w_carry[0] = Cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_stage
            full_adder u_fa (
                .a  (A[i]),
                .b  (B[i]),
                .ci (w_carry[i]),
                .s  (w_sum[i]),
                .co (w_carry[i+1])
            );
        end
    endgenerate

`ifdef RCA_OVERFLOW_EN
    logic ovf_d, ovf_q;
`endif

    // Result registers only move on a valid input; out_valid is a one-cycle strobe.
    always_comb begin
        s_d     = s_q;
        cout_d  = cout_q;
        valid_d = in_valid;
`ifdef RCA_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        if (in_valid) begin
            s_d    = w_sum;
            cout_d = w_carry[WIDTH];
`ifdef RCA_OVERFLOW_EN
            ovf_d  = w_carry[WIDTH] ^ w_carry[WIDTH-1];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef RCA_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            s_q     <= s_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
`ifdef RCA_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign S         = s_q;
    assign Cout      = cout_q;
    assign out_valid = valid_q;
`ifdef RCA_OVERFLOW_EN
    assign Ovf       = ovf_q;
`endif

endmodule : ripple_carry_adder

`default_nettype wire

// File: tb/tb_ripple_carry_adder.sv
// ============================================================================
//  Module  : tb_ripple_carry_adder
//  Purpose : Self-checking bench for ripple_carry_adder against an
//            arithmetic reference model.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ripple_carry_adder;
    import rca_pkg::*;

    localparam int WIDTH = RCA_DEFAULT_WIDTH;
    localparam longint MOD = longint'(1) << WIDTH;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             in_valid;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             out_valid;
`ifdef RCA_OVERFLOW_EN
    logic             Ovf;
`endif

    int          n_tests;
    int          n_fail;
    rca_result_t exp_res;
    logic        exp_ovf;

    ripple_carry_adder #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .in_valid  (in_valid),
        .S         (S),
        .Cout      (Cout),
`ifdef RCA_OVERFLOW_EN
        .Ovf       (Ovf),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on unsigned and signed views.
    task automatic model(input longint a, input longint b, input longint c);
        longint usum, sa, sb, ssum;
        usum = a + b + c;
        sa   = (a >= MOD / 2) ? a - MOD : a;
        sb   = (b >= MOD / 2) ? b - MOD : b;
        ssum = sa + sb + c;
        exp_res = rca_result_t'(usum);
        exp_ovf = (ssum > MOD / 2 - 1) || (ssum < -(MOD / 2));
    endtask

    task automatic check_outputs(input string tag, input logic v);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".sum"}, 64'({Cout, S}), 64'(exp_res));
`ifdef RCA_OVERFLOW_EN
        chk({tag, ".ovf"}, 64'(Ovf), 64'(exp_ovf));
`endif
    endtask

    // Drive one cycle of stimulus and check the registered result after the edge.
    task automatic apply(input string tag, input longint a, input longint b,
                         input longint c, input logic v);
        @(negedge clk);
        A        = a[WIDTH-1:0];
        B        = b[WIDTH-1:0];
        Cin      = c[0];
        in_valid = v;
        @(posedge clk);
        #1;
        if (v) model(a, b, c);
        check_outputs(tag, v);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        A        = '0;
        B        = '0;
        Cin      = 1'b0;
        in_valid = 1'b0;
        exp_res  = '0;
        exp_ovf  = 1'b0;

        #1;
        check_outputs("reset", 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        apply("zero", 0, 0, 0, 1'b1);
        apply("wrap1", MOD - 1, 1, 0, 1'b1);
        apply("wrap2", MOD - 1, MOD - 1, 0, 1'b1);
        apply("max", MOD - 1, MOD - 1, 1, 1'b1);
        apply("cin", 100, 27, 1, 1'b1);
        chk("cin.S128", 64'(S), 64'(128));
        chk("cin.cout0", 64'(Cout), 64'(0));

        // One valid cycle then three idle cycles with garbage on the operands.
        apply("hold.load", 77, 200, 1, 1'b1);
        for (int i = 0; i < 3; i++) apply("hold", $urandom, $urandom, $urandom & 1, 1'b0);

        // Asynchronous reset between edges while a result is being presented.
        apply("pre_rst", 5, 9, 0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_res = '0;
        exp_ovf = 1'b0;
        check_outputs("async_rst", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst", 33, 44, 1, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            apply("rand", longint'($urandom_range(0, 32'(MOD - 1))),
                  longint'($urandom_range(0, 32'(MOD - 1))),
                  longint'($urandom & 1), ($urandom_range(0, 7) != 0));
        end

        for (int i = 0; i < 8; i++) begin
            apply("corner", (i & 1) ? MOD - 1 : MOD / 2, (i & 2) ? MOD / 2 - 1 : MOD / 2,
                  longint'((i >> 2) & 1), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ripple_carry_adder

`default_nettype wire
